// File: rtl/frog_log_monitor_pkg.sv
// Shared types and defaults for the frog/log overlap monitor.
package frog_log_monitor_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, EVAL, REPORT} state_t;

  localparam int DEFAULT_NUM_OF_LOGS = 2;
  localparam int DEFAULT_MIN_OVERLAP = 16;
  localparam int DEFAULT_CNT_W       = 12;

  // A single log still needs a one-bit index so the port never collapses to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frog_log_monitor_if.sv
// Per-frame result handshake between the monitor and whatever consumes its events.
interface frog_log_monitor_if
  import frog_log_monitor_pkg::*;
#(
  parameter int NUM_OF_LOGS = DEFAULT_NUM_OF_LOGS
);
  localparam int IDX_W = idx_width(NUM_OF_LOGS);

  logic             event_valid;
  logic             event_ack;
  logic             frog_on_log;
  logic [IDX_W-1:0] log_index;
  logic             frog_drowned;
  logic             overrun;

  modport master (
    output event_valid, frog_on_log, log_index, frog_drowned, overrun,
    input  event_ack
  );

  modport slave (
    input  event_valid, frog_on_log, log_index, frog_drowned, overrun,
    output event_ack
  );

endinterface

// File: rtl/frog_log_monitor_sat_counter.sv
// Pixel counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 12
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/frog_log_monitor.sv
// Counts frog/log/water pixel overlaps over one frame and reports whether the
// frog rode a log, drowned, or neither, through a valid/ack event port.
module frog_log_monitor
  import frog_log_monitor_pkg::*;
#(
  parameter int NUM_OF_LOGS = DEFAULT_NUM_OF_LOGS,
  parameter int MIN_OVERLAP = DEFAULT_MIN_OVERLAP,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   startOfFrame,
  input  logic                   enable,
  input  logic                   frog_drawing_request,
  input  logic [NUM_OF_LOGS-1:0] log_drawing_request,
  input  logic                   water_drawing_request,
  frog_log_monitor_if.master     evt
);

  localparam int               IDX_W  = idx_width(NUM_OF_LOGS);
  localparam logic [CNT_W-1:0] MIN_OV = CNT_W'(MIN_OVERLAP);

  state_t state, next_state;

  logic [CNT_W-1:0]       frog_cnt;
  logic [CNT_W-1:0]       wet_cnt;
  logic [CNT_W-1:0]       ov_cnt [NUM_OF_LOGS];
  logic [NUM_OF_LOGS-1:0] ov_inc;

  logic             scan_pixel, cnt_clr, load_result, ack_taken;
  logic             has_event, res_on_log, res_drowned;
  logic [IDX_W-1:0] best_idx, res_index;
  logic [CNT_W-1:0] best_ov;

  // The frame-boundary pulse itself is never counted, so it can close one scan and open the next.
  assign ov_inc    = {NUM_OF_LOGS{scan_pixel & frog_drawing_request}} & log_drawing_request;
  assign ack_taken = evt.event_valid & evt.event_ack;

  sat_counter #(.CNT_W(CNT_W)) u_frog_cnt (
    .CLK    (CLK),
    .RESETn (RESETn),
    .inc    (scan_pixel & frog_drawing_request),
    .clr    (cnt_clr),
    .count  (frog_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wet_cnt (
    .CLK    (CLK),
    .RESETn (RESETn),
    .inc    (scan_pixel & frog_drawing_request & water_drawing_request & ~(|log_drawing_request)),
    .clr    (cnt_clr),
    .count  (wet_cnt)
  );

  for (genvar i = 0; i < NUM_OF_LOGS; i++) begin : g_ov
    sat_counter #(.CNT_W(CNT_W)) u_ov_cnt (
      .CLK    (CLK),
      .RESETn (RESETn),
      .inc    (ov_inc[i]),
      .clr    (cnt_clr),
      .count  (ov_cnt[i])
    );
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (startOfFrame) next_state = SCAN;
        SCAN:    if (startOfFrame) next_state = EVAL;
        EVAL:    next_state = has_event ? REPORT : SCAN;
        REPORT:  next_state = SCAN;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    scan_pixel  = enable && (state == SCAN) && !startOfFrame;
    cnt_clr     = !enable || (state == EVAL);
    load_result = enable && (state == EVAL) && has_event;
  end

  // Strict greater-than keeps the first (lowest-index) log on ties.
  always_comb begin
    best_idx = '0;
    best_ov  = ov_cnt[0];
    for (int i = 1; i < NUM_OF_LOGS; i++) begin
      if (ov_cnt[i] > best_ov) begin
        best_ov  = ov_cnt[i];
        best_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    has_event   = 1'b0;
    res_on_log  = 1'b0;
    res_drowned = 1'b0;
    if (frog_cnt != '0) begin
      if (best_ov >= MIN_OV) begin
        has_event  = 1'b1;
        res_on_log = 1'b1;
      end else if (wet_cnt != '0) begin
        has_event   = 1'b1;
        res_drowned = 1'b1;
      end
    end
    res_index = res_on_log ? best_idx : '0;
  end

  // A result landing on an unacknowledged one is dropped; an ack in the same cycle makes room.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      evt.event_valid  <= 1'b0;
      evt.frog_on_log  <= 1'b0;
      evt.log_index    <= '0;
      evt.frog_drowned <= 1'b0;
      evt.overrun      <= 1'b0;
    end else if (load_result) begin
      if (evt.event_valid && !ack_taken) begin
        evt.overrun <= 1'b1;
      end else begin
        evt.event_valid  <= 1'b1;
        evt.frog_on_log  <= res_on_log;
        evt.log_index    <= res_index;
        evt.frog_drowned <= res_drowned;
      end
    end else if (ack_taken) begin
      evt.event_valid  <= 1'b0;
      evt.frog_on_log  <= 1'b0;
      evt.log_index    <= '0;
      evt.frog_drowned <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frog_log_monitor.sv
// Directed checks of the frog/log monitor: results, tie rule, threshold, handshake, saturation, reset.
module tb_frog_log_monitor;
  import frog_log_monitor_pkg::*;

  logic       CLK;
  logic       RESETn;
  logic       startOfFrame;
  logic       enable;
  logic       frog_req;
  logic [1:0] log_req;
  logic       water_req;

  int n_cmp  = 0;
  int n_fail = 0;

  frog_log_monitor_if #(.NUM_OF_LOGS(2)) evt_if ();

  frog_log_monitor #(.NUM_OF_LOGS(2), .MIN_OVERLAP(16), .CNT_W(12)) dut (
    .CLK                   (CLK),
    .RESETn                (RESETn),
    .startOfFrame          (startOfFrame),
    .enable                (enable),
    .frog_drawing_request  (frog_req),
    .log_drawing_request   (log_req),
    .water_drawing_request (water_req),
    .evt                   (evt_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_px(input int n, input logic f, input logic [1:0] l, input logic w);
    for (int i = 0; i < n; i++) begin
      frog_req  = f;
      log_req   = l;
      water_req = w;
      tick();
    end
    frog_req  = 1'b0;
    log_req   = 2'b00;
    water_req = 1'b0;
  endtask

  // Leaves the bench in the EVAL cycle, one edge after the boundary pulse was sampled.
  task automatic end_frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic ack();
    evt_if.event_ack = 1'b1;
    tick();
    evt_if.event_ack = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (evt_if.event_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.valid got=%b want=0", evt_if.event_valid); end
    n_cmp++; if (evt_if.frog_on_log !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.on_log got=%b want=0", evt_if.frog_on_log); end
    n_cmp++; if (evt_if.log_index !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.index got=%b want=0", evt_if.log_index); end
    n_cmp++; if (evt_if.frog_drowned !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.drowned got=%b want=0", evt_if.frog_drowned); end
    n_cmp++; if (evt_if.overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.overrun got=%b want=0", evt_if.overrun); end
    n_cmp++; if (dut.state !== IDLE) begin n_fail++; $display("[TB] FAIL reset.state got=%0d want=%0d", dut.state, IDLE); end
  endtask

  task automatic test_on_log();
    drive_px(256, 1'b1, 2'b10, 1'b1);
    end_frame();
    n_cmp++; if (evt_if.event_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL on_log.early_valid got=%b want=0", evt_if.event_valid); end
    tick();
    n_cmp++; if (evt_if.event_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL on_log.valid got=%b want=1", evt_if.event_valid); end
    n_cmp++; if (evt_if.frog_on_log !== 1'b1) begin n_fail++; $display("[TB] FAIL on_log.on_log got=%b want=1", evt_if.frog_on_log); end
    n_cmp++; if (evt_if.log_index !== 1'b1) begin n_fail++; $display("[TB] FAIL on_log.index got=%b want=1", evt_if.log_index); end
    n_cmp++; if (evt_if.frog_drowned !== 1'b0) begin n_fail++; $display("[TB] FAIL on_log.drowned got=%b want=0", evt_if.frog_drowned); end
    tick();
    n_cmp++; if (evt_if.event_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL on_log.held got=%b want=1", evt_if.event_valid); end
    ack();
    n_cmp++; if (evt_if.event_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL on_log.ack_valid got=%b want=0", evt_if.event_valid); end
    n_cmp++; if (evt_if.frog_on_log !== 1'b0) begin n_fail++; $display("[TB] FAIL on_log.ack_flag got=%b want=0", evt_if.frog_on_log); end
  endtask

  task automatic test_drowned();
    drive_px(256, 1'b1, 2'b00, 1'b1);
    drive_px(10, 1'b1, 2'b01, 1'b1);
    end_frame();
    tick();
    n_cmp++; if (evt_if.event_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL drowned.valid got=%b want=1", evt_if.event_valid); end
    n_cmp++; if (evt_if.frog_drowned !== 1'b1) begin n_fail++; $display("[TB] FAIL drowned.drowned got=%b want=1", evt_if.frog_drowned); end
    n_cmp++; if (evt_if.frog_on_log !== 1'b0) begin n_fail++; $display("[TB] FAIL drowned.on_log got=%b want=0", evt_if.frog_on_log); end
    ack();
  endtask

  task automatic test_tie_and_threshold();
    drive_px(20, 1'b1, 2'b01, 1'b1);
    drive_px(20, 1'b1, 2'b10, 1'b1);
    end_frame();
    tick();
    n_cmp++; if (evt_if.frog_on_log !== 1'b1) begin n_fail++; $display("[TB] FAIL tie.on_log got=%b want=1", evt_if.frog_on_log); end
    n_cmp++; if (evt_if.log_index !== 1'b0) begin n_fail++; $display("[TB] FAIL tie.index got=%b want=0", evt_if.log_index); end
    ack();
    drive_px(10, 1'b1, 2'b01, 1'b0);
    drive_px(30, 1'b1, 2'b10, 1'b0);
    end_frame();
    tick();
    n_cmp++; if (evt_if.log_index !== 1'b1) begin n_fail++; $display("[TB] FAIL best.index got=%b want=1", evt_if.log_index); end
    ack();
    drive_px(16, 1'b1, 2'b01, 1'b0);
    end_frame();
    tick();
    n_cmp++; if (evt_if.frog_on_log !== 1'b1) begin n_fail++; $display("[TB] FAIL thresh16.on_log got=%b want=1", evt_if.frog_on_log); end
    ack();
    drive_px(15, 1'b1, 2'b01, 1'b0);
    end_frame();
    tick();
    n_cmp++; if (evt_if.event_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL thresh15.valid got=%b want=0", evt_if.event_valid); end
    drive_px(40, 1'b0, 2'b01, 1'b1);
    end_frame();
    tick();
    n_cmp++; if (evt_if.event_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL no_frog.valid got=%b want=0", evt_if.event_valid); end
  endtask

  task automatic test_enable();
    drive_px(20, 1'b1, 2'b01, 1'b0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    drive_px(5, 1'b1, 2'b01, 1'b0);
    n_cmp++; if (dut.ov_cnt[0] !== 12'd5) begin n_fail++; $display("[TB] FAIL enable.ov_cnt got=%0d want=5", dut.ov_cnt[0]); end
    end_frame();
    tick();
    n_cmp++; if (evt_if.event_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL enable.valid got=%b want=0", evt_if.event_valid); end
  endtask

  task automatic test_simul_ack();
    drive_px(20, 1'b1, 2'b10, 1'b0);
    end_frame();
    tick();
    drive_px(1, 1'b0, 2'b00, 1'b0);
    drive_px(30, 1'b1, 2'b00, 1'b1);
    end_frame();
    evt_if.event_ack = 1'b1;
    tick();
    evt_if.event_ack = 1'b0;
    n_cmp++; if (evt_if.event_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL simul.valid got=%b want=1", evt_if.event_valid); end
    n_cmp++; if (evt_if.frog_drowned !== 1'b1) begin n_fail++; $display("[TB] FAIL simul.drowned got=%b want=1", evt_if.frog_drowned); end
    n_cmp++; if (evt_if.frog_on_log !== 1'b0) begin n_fail++; $display("[TB] FAIL simul.on_log got=%b want=0", evt_if.frog_on_log); end
    n_cmp++; if (evt_if.overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL simul.overrun got=%b want=0", evt_if.overrun); end
    ack();
  endtask

  task automatic test_back_to_back();
    drive_px(20, 1'b1, 2'b10, 1'b1);
    end_frame();
    tick();
    drive_px(1, 1'b0, 2'b00, 1'b0);
    drive_px(30, 1'b1, 2'b00, 1'b1);
    end_frame();
    tick();
    n_cmp++; if (evt_if.overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b.overrun got=%b want=1", evt_if.overrun); end
    n_cmp++; if (evt_if.frog_on_log !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b.kept_on_log got=%b want=1", evt_if.frog_on_log); end
    n_cmp++; if (evt_if.log_index !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b.kept_index got=%b want=1", evt_if.log_index); end
    n_cmp++; if (evt_if.frog_drowned !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b.kept_drowned got=%b want=0", evt_if.frog_drowned); end
    ack();
    n_cmp++; if (evt_if.event_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b.ack_valid got=%b want=0", evt_if.event_valid); end
    n_cmp++; if (evt_if.overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b.sticky got=%b want=1", evt_if.overrun); end
    ack();
    n_cmp++; if (evt_if.event_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_ack.valid got=%b want=0", evt_if.event_valid); end
  endtask

  task automatic test_saturation();
    drive_px(4096, 1'b1, 2'b01, 1'b1);
    n_cmp++; if (dut.ov_cnt[0] !== 12'd4095) begin n_fail++; $display("[TB] FAIL sat.ov_cnt got=%0d want=4095", dut.ov_cnt[0]); end
    n_cmp++; if (dut.frog_cnt !== 12'd4095) begin n_fail++; $display("[TB] FAIL sat.frog_cnt got=%0d want=4095", dut.frog_cnt); end
    end_frame();
    tick();
    n_cmp++; if (evt_if.frog_on_log !== 1'b1) begin n_fail++; $display("[TB] FAIL sat.on_log got=%b want=1", evt_if.frog_on_log); end
    n_cmp++; if (evt_if.log_index !== 1'b0) begin n_fail++; $display("[TB] FAIL sat.index got=%b want=0", evt_if.log_index); end
    ack();
  endtask

  task automatic test_reset_mid_scan();
    drive_px(20, 1'b1, 2'b01, 1'b0);
    end_frame();
    tick();
    drive_px(100, 1'b1, 2'b01, 1'b0);
    RESETn = 1'b0;
    #2;
    n_cmp++; if (evt_if.event_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid.valid got=%b want=0", evt_if.event_valid); end
    n_cmp++; if (evt_if.frog_on_log !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid.on_log got=%b want=0", evt_if.frog_on_log); end
    n_cmp++; if (evt_if.overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid.overrun got=%b want=0", evt_if.overrun); end
    n_cmp++; if (dut.ov_cnt[0] !== 12'd0) begin n_fail++; $display("[TB] FAIL rst_mid.ov_cnt got=%0d want=0", dut.ov_cnt[0]); end
    tick();
    RESETn = 1'b1;
    drive_px(50, 1'b1, 2'b01, 1'b0);
    end_frame();
    n_cmp++; if (evt_if.event_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid.open_valid got=%b want=0", evt_if.event_valid); end
    tick();
    n_cmp++; if (evt_if.event_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid.open_valid2 got=%b want=0", evt_if.event_valid); end
    drive_px(30, 1'b1, 2'b01, 1'b0);
    end_frame();
    tick();
    n_cmp++; if (evt_if.event_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid.frame_valid got=%b want=1", evt_if.event_valid); end
    n_cmp++; if (evt_if.frog_on_log !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid.frame_on_log got=%b want=1", evt_if.frog_on_log); end
    ack();
  endtask

  initial begin
    RESETn           = 1'b0;
    startOfFrame     = 1'b0;
    enable           = 1'b1;
    frog_req         = 1'b0;
    log_req          = 2'b00;
    water_req        = 1'b0;
    evt_if.event_ack = 1'b0;
    repeat (3) tick();
    test_reset();
    RESETn = 1'b1;
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    test_on_log();
    test_drowned();
    test_tie_and_threshold();
    test_enable();
    test_simul_ack();
    test_back_to_back();
    test_saturation();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frog_log_monitor.md
FROG_LOG_MONITOR -- requirements
Module: frog_log_monitor

Interface
REQ-001 Parameter NUM_OF_LOGS, default 2, number of log drawing-request lanes consumed.
REQ-002 Parameter MIN_OVERLAP, default 16, minimum frog/log overlap pixels per frame for "on log".
REQ-003 Parameter CNT_W, default 12, width of every pixel counter.
REQ-004 CLK  input  1  system pixel clock.
REQ-005 RESETn  input  1  reset; one clock, asynchronous, active-low.
REQ-006 startOfFrame  input  1  single-cycle pulse marking the first pixel of a new frame.
REQ-007 enable  input  1  monitor enable; low clears counters and suppresses events.
REQ-008 frog_drawing_request  input  1  frog sprite owns the current pixel.
REQ-009 log_drawing_request  input  NUM_OF_LOGS  per-log drawing request for the current pixel.
REQ-010 water_drawing_request  input  1  current pixel lies in the water band.
REQ-011 event_valid  output  1  frame result pending; held until acknowledged.
REQ-012 event_ack  input  1  consumer accepts the pending result.
REQ-013 frog_on_log  output  1  result: frog rides a log.
REQ-014 log_index  output  1 (clog2 NUM_OF_LOGS, min 1)  result: log carrying the frog.
REQ-015 frog_drowned  output  1  result: frog over water with no log support.
REQ-016 overrun  output  1  sticky: a result was dropped while event_valid was high.

Function
REQ-017 State machine SHALL have states IDLE, SCAN, EVAL, REPORT.
REQ-018 IDLE -> SCAN on startOfFrame with enable high; no counting in IDLE.
REQ-019 In SCAN, each cycle with frog_drawing_request high SHALL increment frog_cnt.
REQ-020 In SCAN, each cycle with frog and log_drawing_request[i] high SHALL increment ov_cnt[i].
REQ-021 In SCAN, each cycle with frog and water high and no log request SHALL increment wet_cnt.
REQ-022 All counters SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-023 SCAN -> EVAL on the next startOfFrame; that same startOfFrame cycle is not counted.
REQ-024 EVAL (one cycle) SHALL pick the best log = largest ov_cnt; ties resolve to the lowest index.
REQ-025 EVAL result: frog_cnt==0 -> no event; best ov_cnt>=MIN_OVERLAP -> on_log with best index; else wet_cnt>0 -> drowned; else no event.
REQ-026 EVAL -> REPORT when an event exists, else -> SCAN; counters SHALL clear on leaving EVAL.
REQ-027 REPORT SHALL load frog_on_log/log_index/frog_drowned and assert event_valid the cycle after EVAL (result latency 2 cycles after frame-ending startOfFrame), then go to SCAN.
REQ-028 event_valid and result outputs SHALL stay stable until the cycle after event_ack is sampled high with event_valid high; then event_valid and result flags clear.
REQ-029 A new result arriving while event_valid is high SHALL be dropped and set overrun; the pending result is unchanged.
REQ-030 event_ack with event_valid low SHALL be ignored.
REQ-031 Simultaneous ack and new result in the same cycle: the ack retires the old result, the new one is loaded next cycle, no overrun.
REQ-032 The startOfFrame that ends the scan is also the start of the next scan; no frame is skipped.
REQ-033 enable low in any state SHALL force IDLE and clear counters; a pending event_valid remains until acked.
REQ-034 overrun SHALL clear only on reset.

Reset
REQ-035 On RESETn low: state IDLE, all counters 0, event_valid 0, frog_on_log 0, log_index 0, frog_drowned 0, overrun 0.
REQ-036 Reset asserted mid-frame SHALL discard the partial scan; the first full frame after release starts at the next startOfFrame.

Structure
REQ-037 A shared package SHALL hold the state enum, default NUM_OF_LOGS and MIN_OVERLAP constants.
REQ-038 One sub-module, sat_counter (parameter CNT_W; inputs inc, clr), SHALL be instantiated per counter.

Verification
REQ-039 Frog 16x16 fully over log 1, log 0 absent -> event_valid, frog_on_log=1, log_index=1, frog_drowned=0, 2 cycles after the next startOfFrame.
REQ-040 Frog 256 px over water, 10 px on log 0 -> frog_drowned=1, frog_on_log=0.
REQ-041 Frog 20 px on log 0 and 20 px on log 1 -> frog_on_log=1, log_index=0 (tie rule).
REQ-042 Two results, no ack -> first result held, overrun=1; then ack -> event_valid=0 next cycle.
REQ-043 Frog 4096 px all over log 0 -> ov_cnt saturates at 4095, on_log result, no wrap.
REQ-044 RESETn pulsed low mid-SCAN -> all outputs 0; no event until one full frame after release.
